strip_id_sequencer: RTL

Parametrised strip-ID lookup with a runtime-loadable table. A preprocessed height address selects one entry of NUM_CAND candidate strip IDs, stored in priority order. The block streams the valid candidates one per beat over a valid/ready interface and skips INVALID_ID codes. It sits between the height preprocessor and the strip-assignment logic, and allows table updates without resynthesis.

---
 rtl/strip_id_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/strip_id_sequencer.sv
// strip_id_sequencer: maps a preprocessed height address to a table entry
// of prioritised strip-ID candidates and streams the valid ones, one per
// beat, over a valid/ready interface. The table can be rewritten at run time.
module strip_id_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int NUM_ENTRIES = 10,
  parameter int ID_W        = 4,
  parameter int NUM_CAND    = 3,
  parameter logic [ID_W-1:0] INVALID_ID = 4'hD,
  parameter logic [NUM_ENTRIES*NUM_CAND*ID_W-1:0] INIT_TABLE =
    120'hCBA_8DD_68D_46D_24D_012_301_53D_75D_97D,
  localparam int SLOT_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ID_W-1:0]          out_id,
  output logic [SLOT_W-1:0]        out_slot,
  output logic                     out_last,
  output logic                     out_none,
  output logic                     out_clamped,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [NUM_CAND*ID_W-1:0] cfg_data,
  output logic                     busy
);

  localparam int ENTRY_W = NUM_CAND * ID_W;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                               state_q, state_d;
  logic [NUM_ENTRIES-1:0][ENTRY_W-1:0]  table_q;
  logic [ENTRY_W-1:0]                   entry_q, entry_d;
  logic [NUM_CAND-1:0]                  mask_q, mask_d;
  logic                                 clamped_q, clamped_d;

  logic                                 reqClamp;
  logic [ADDR_W-1:0]                    effAddr;
  logic [ENTRY_W-1:0]                   lookupEntry;
  logic [NUM_CAND-1:0]                  lookupMask;
  logic [SLOT_W-1:0]                    selSlot;
  logic [ID_W-1:0]                      selId;
  logic                                 onlyOne;

  // Clamp the request address to the catch-all entry and build the pending
  // mask of the entry as it stands before any same-cycle config write.
  always_comb begin
    reqClamp    = 32'(req_addr) >= 32'(NUM_ENTRIES);
    effAddr     = reqClamp ? ADDR_W'(NUM_ENTRIES - 1) : req_addr;
    lookupEntry = table_q[effAddr];
    lookupMask  = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      lookupMask[k] = lookupEntry[(NUM_CAND-1-k)*ID_W +: ID_W] != INVALID_ID;
    end
  end

  // Pick the lowest-index pending candidate from the snapshot; candidate 0
  // lives in the most-significant field of the entry.
  always_comb begin
    selSlot = '0;
    selId   = INVALID_ID;
    for (int k = NUM_CAND - 1; k >= 0; k--) begin
      if (mask_q[k]) begin
        selSlot = SLOT_W'(k);
        selId   = entry_q[(NUM_CAND-1-k)*ID_W +: ID_W];
      end
    end
    onlyOne = (mask_q & (mask_q - NUM_CAND'(1))) == '0;
  end

  // Next-state and output decode: accept in IDLE, stream beats in EMIT,
  // retiring one pending candidate per handshake.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    mask_d      = mask_q;
    clamped_d   = clamped_q;
    req_ready   = 1'b0;
    out_valid   = 1'b0;
    out_id      = '0;
    out_slot    = '0;
    out_last    = 1'b0;
    out_none    = 1'b0;
    out_clamped = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          entry_d   = lookupEntry;
          mask_d    = lookupMask;
          clamped_d = reqClamp;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        out_valid   = 1'b1;
        out_clamped = clamped_q;
        if (mask_q != '0) begin
          out_id   = selId;
          out_slot = selSlot;
          out_last = onlyOne;
        end else begin
          out_id   = INVALID_ID;
          out_none = 1'b1;
          out_last = 1'b1;
        end
        if (out_ready) begin
          mask_d = mask_q & ~(NUM_CAND'(1) << selSlot);
          if (out_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request state registers; reset abandons any stream in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      entry_q   <= '0;
      mask_q    <= '0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      mask_q    <= mask_d;
      clamped_q <= clamped_d;
    end
  end

  // Lookup table: reloads its power-on contents on reset, otherwise takes
  // in-range config writes in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      table_q <= INIT_TABLE;
    end else if (cfg_we && (32'(cfg_addr) < 32'(NUM_ENTRIES))) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
